// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit port: FSM states, register offsets
// and STATUS register bit positions.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int DATA_OFS   = 0;
    localparam int STATUS_OFS = 4;

    localparam int ST_FULL  = 0;
    localparam int ST_EMPTY = 1;
    localparam int ST_BUSY  = 2;
    localparam int ST_COUNT = 3;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-around pointers carrying an extra MSB so that
// full and empty are distinguishable without a separate counter.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         do_push, do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign count = wptr - rptr;
    assign rdata = mem[rptr[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push to a full FIFO is kept.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wptr[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: DATA register feeds a TX FIFO, a
// serialiser drains it, STATUS exposes full/empty/busy/count for polling.
module uart_tx_port
    import uart_pkg::*;
#(
    parameter int                WIDTH   = 32,
    parameter logic [WIDTH-1:0]  BASE    = 32'h000F_0000,
    parameter int                CLKRATE = 25000000,
    parameter int                BAUD    = 115200,
    parameter int                DEPTH   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] address,
    input  logic [WIDTH-1:0] wdata,
    input  logic             enw,
    output logic [WIDTH-1:0] rdata,
    output logic             txd,
    output logic             busy
);

    localparam int DIV  = CLKRATE / BAUD;
    localparam int CNTW = $clog2(DIV);
    localparam int CW   = $clog2(DEPTH) + 1;

    localparam logic [WIDTH-1:0] DATA_ADDR   = BASE + WIDTH'(DATA_OFS);
    localparam logic [WIDTH-1:0] STATUS_ADDR = BASE + WIDTH'(STATUS_OFS);

    tx_state_t       state, state_nx;
    logic [CNTW-1:0] baud_cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift, head;
    logic            push, pop, full, empty, wrap, txd_nx;
    logic [CW-1:0]   count;
    logic            unused_wdata_hi;

    assign unused_wdata_hi = ^wdata[WIDTH-1:8];

    assign push = enw && (address == DATA_ADDR);
    assign wrap = (baud_cnt == CNTW'(DIV - 1));
    assign busy = (count != '0) || (state != IDLE);

    sync_fifo #(.W(8), .DEPTH(DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata[7:0]),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (!empty)                 state_nx = START;
            START: if (wrap)                   state_nx = DATA;
            DATA:  if (wrap && bit_idx == 3'd7) state_nx = STOP;
            STOP:  if (wrap)                   state_nx = empty ? IDLE : START;
            default:                           state_nx = IDLE;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        txd_nx = 1'b1;
        case (state)
            IDLE:  pop    = !empty;
            START: txd_nx = 1'b0;
            DATA:  txd_nx = shift[0];
            STOP:  pop    = wrap && !empty;
            default: ;
        endcase
    end

    // Baud counter, bit index and shift register; the popped byte is loaded
    // on the same edge that the FSM enters START.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else if (state == IDLE) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (pop) shift <= head;
        end else begin
            baud_cnt <= wrap ? '0 : baud_cnt + 1'b1;
            if (wrap) begin
                case (state)
                    START: bit_idx <= '0;
                    DATA: begin
                        shift   <= shift >> 1;
                        bit_idx <= bit_idx + 1'b1;
                    end
                    STOP: if (pop) shift <= head;
                    default: ;
                endcase
            end
        end
    end

    // Registered line driver: every bit lands one clock after its state edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) txd <= 1'b1;
        else       txd <= txd_nx;
    end

    always_comb begin
        rdata = '0;
        if (address == STATUS_ADDR) begin
            rdata[ST_FULL]       = full;
            rdata[ST_EMPTY]      = empty;
            rdata[ST_BUSY]       = busy;
            rdata[ST_COUNT +: CW] = count;
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed plus randomized bench for uart_tx_port; expected line and STATUS
// values come from frame-level arithmetic over a queue of bytes.
module tb_uart_tx_port;

    localparam int          WIDTH   = 32;
    localparam logic [31:0] BASE    = 32'h000F_0000;
    localparam int          CLKRATE = 40;
    localparam int          BAUD    = 10;
    localparam int          DEPTH   = 4;
    localparam int          DIV     = CLKRATE / BAUD;
    localparam int          FL      = 10 * DIV;
    localparam logic [31:0] STATUS_ADDR = BASE + 32'd4;

    logic        clock, reset, enw, txd, busy;
    logic [31:0] address, wdata, rdata;

    int          nchk = 0;
    int          npass = 0;
    logic [7:0]  bq[$];

    uart_tx_port #(.WIDTH(WIDTH), .BASE(BASE), .CLKRATE(CLKRATE), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clock   (clock),
        .reset   (reset),
        .address (address),
        .wdata   (wdata),
        .enw     (enw),
        .rdata   (rdata),
        .txd     (txd),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_status(input string tag, input logic [31:0] exp);
        address = STATUS_ADDR;
        #1;
        check(tag, rdata, exp);
    endtask

    // Line level t clocks after the first push edge, for nf frames queued in bq.
    function automatic logic exp_txd(input int t, input int nf);
        int u, s;
        logic [7:0] b;
        if (t < 2 || t >= 2 + FL * nf) return 1'b1;
        u = t - 2;
        b = bq[u / FL];
        s = (u % FL) / DIV;
        if (s == 0) return 1'b0;
        if (s == 9) return 1'b1;
        return b[s-1];
    endfunction

    // Push bq[0..n-1] on consecutive edges from idle, then check every clock.
    // The first byte leaves the FIFO at once, so at most DEPTH+1 are accepted.
    task automatic run_burst(input int n, input string tag);
        int nf, T, cnt;
        logic [31:0] w;
        nf  = (n < DEPTH + 1) ? n : DEPTH + 1;
        T   = 2 + FL * nf + 4;
        cnt = (n == 1) ? 1 : ((n - 1 < DEPTH) ? n - 1 : DEPTH);
        for (int t = 0; t < T; t++) begin
            enw     = (t < n);
            address = (t < n) ? BASE : STATUS_ADDR;
            w       = $urandom;
            if (t < n) w[7:0] = bq[t];
            wdata   = w;
            @(posedge clock);
            @(negedge clock);
            enw = 1'b0;
            check({tag, "_txd"}, 32'(txd), 32'(exp_txd(t, nf)));
            check({tag, "_busy"}, 32'(busy), 32'(t <= FL * nf));
            if (t == n - 1)
                check_status({tag, "_stat"}, (32'(cnt) << 3) | 32'h4 | 32'(cnt == DEPTH));
        end
        check_status({tag, "_end"}, 32'h2);
    endtask

    initial begin
        reset   = 1'b1;
        enw     = 1'b0;
        address = '0;
        wdata   = '0;
        #12;
        check("rst_txd", 32'(txd), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check_status("rst_stat", 32'h2);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_status("idle_stat", 32'h2);
        address = BASE;
        #1;
        check("data_rd", rdata, 32'h0);

        bq = {8'h55};
        run_burst(1, "b55");

        bq = {8'h01, 8'h80};
        run_burst(2, "b2");

        bq = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        run_burst(6, "ovf");

        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, DEPTH + 2);
            bq.delete();
            for (int i = 0; i < n; i++) bq.push_back(8'($urandom));
            run_burst(n, "rnd");
        end

        // Reset in the middle of a frame with bytes still queued.
        bq = {8'h00, 8'hA5, 8'h3C};
        for (int t = 0; t <= 14; t++) begin
            enw     = (t < 3);
            address = BASE;
            wdata   = {24'hABCDEF, (t < 3) ? bq[t] : 8'h00};
            @(posedge clock);
            @(negedge clock);
            enw = 1'b0;
        end
        check("mid_txd_low", 32'(txd), 32'h0);
        reset = 1'b1;
        #1;
        check("mid_rst_txd", 32'(txd), 32'h1);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check_status("mid_rst_stat", 32'h2);
        @(negedge clock);
        reset = 1'b0;
        for (int t = 0; t < 60; t++) begin
            @(negedge clock);
            check("post_rst_txd", 32'(txd), 32'h1);
        end
        check_status("post_rst_stat", 32'h2);

        // Unmapped address: reads zero, writes ignored.
        address = BASE + 32'd8;
        wdata   = 32'h1234_5678;
        enw     = 1'b1;
        #1;
        check("unmap_rd", rdata, 32'h0);
        @(posedge clock);
        @(negedge clock);
        enw = 1'b0;
        check_status("unmap_stat", 32'h2);
        for (int t = 0; t < 8; t++) begin
            @(negedge clock);
            check("unmap_txd", 32'(txd), 32'h1);
        end

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/uart_tx_port.md
Name: uart_tx_port

Overview:
- Memory-mapped UART transmitter on the core's data bus, alongside the panel; the core's outbound path to a host PC.
- The core writes bytes into a TX FIFO; an 8N1 serialiser shifts them out on a single line.
- A status register lets firmware poll for free FIFO space and for completion.

Parameters:
- WIDTH, 32, data bus and address width in bits.
- BASE, 32'h000F_0000, byte address of the DATA register. STATUS is at BASE+4.
- CLKRATE, 25000000, clock frequency in Hz.
- BAUD, 115200, line rate. DIV = CLKRATE/BAUD clocks per bit, truncated. DIV must be >= 2.
- DEPTH, 8, FIFO entries. Must be a power of two, >= 2.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- address  in  WIDTH  core data-bus byte address.
- wdata  in  WIDTH  core write data.
- enw  in  1  write strobe, sampled at rising clock edge.
- rdata  out  WIDTH  read data, combinational on address.
- txd  out  1  serial output; idle high.
- busy  out  1  high while the FIFO is non-empty or a frame is in flight.

Behaviour:
- Reset (async, active-high): FIFO empty, FSM IDLE, baud counter 0, bit index 0, txd=1, busy=0.
- Register map:
  - DATA (BASE), write only. Reads return 0.
  - STATUS (BASE+4), read only: bit0 full, bit1 empty, bit2 busy, bits[3+:CW] FIFO count, other bits 0. CW = $clog2(DEPTH)+1.
  - Any other address: rdata=0, writes ignored.
- Write to DATA: enw && address==BASE pushes wdata[7:0] at the clock edge. Upper bits are discarded.
  - Push while full: byte dropped, FIFO unchanged.
  - There is no error flag; firmware must poll full first.
- Read latency 0: STATUS reflects the current registered state. A push at edge N is visible in count after edge N.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop the head into an 8-bit shift register, go to START, clear the baud counter. txd=1.
  - START: txd=0 for DIV clocks, then go to DATA with bit index 0.
  - DATA: txd=shift[0], LSB first. Each DIV clocks, shift right and increment the index. After bit 7's period go to STOP.
  - STOP: txd=1 for DIV clocks. Then, if the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Frame length: exactly 10*DIV clocks. txd is registered, so it changes one cycle after the state/counter edge. This offset is fixed and applies to every bit.
- Baud counter counts 0..DIV-1, wraps, and advances the bit on the wrap.
- Same-cycle push and pop: both happen and count is unchanged. Push to a full FIFO in the same cycle as a pop is accepted, because full is evaluated after the pop.
- busy = (count != 0) || (state != IDLE). It is registered-state derived with no extra latency.
- Reset mid-frame: the line returns to 1 immediately and the partial frame is abandoned. FIFO contents are lost.

Decomposition:
- Shared package uart_pkg:
  - state enum tx_state_t {IDLE, START, DATA, STOP}.
  - Register offsets DATA_OFS=0, STATUS_OFS=4.
  - STATUS bit positions.
- One sub-module sync_fifo #(W=8, DEPTH): push/pop/full/empty/count, wrap-around pointers with an extra MSB. It is reusable by a future UART receiver.

Test Plan (CLKRATE=40, BAUD=10 -> DIV=4, DEPTH=4 unless noted):
- Reset, then read STATUS -> 32'h0000_0002 (empty=1, count=0). txd=1, busy=0.
- Write 32'hFFFF_FF55 to BASE -> after 1 cycle busy=1.
  - txd sequence in 4-clock slices: 0,1,0,1,0,1,0,1,0,1 (start, 0x55 LSB first, stop).
  - busy=0 exactly 40 clocks after the pop.
- Write 0x01 and 0x80 in consecutive cycles -> two frames back to back, 80 clocks total, no idle gap between stop and start.
- With the FSM stalled mid-frame, push 5 bytes -> the first is popped, then count=4 and full=1 (STATUS bit0). The 6th write is dropped, and only 5 frames are transmitted.
- Assert reset at clock 14 of a frame -> txd=1 and STATUS=32'h2 immediately, with no further start bits.
- Read address BASE+8 and write it with enw -> rdata=0, and the FIFO count is unchanged.
